gpr_multiport: RTL and testbench

//   Parametrised multi-port integer register file with scoreboard; successor to the single-write GPR.
//   NUM_RD read ports and NUM_WR write ports, x0 hard-wired zero, write-first bypass on every read.

---
 rtl/gpr_multiport.sv | 138 +++++++++++++
 tb/tb_gpr_multiport.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/gpr_multiport.sv
// Multi-port integer register file with a per-register busy scoreboard.
// x0 reads as zero, every read port bypasses same-cycle writes (write-first),
// and after reset a sequential sweep clears the array before traffic is accepted.
//
// Ports:
//   clk, rst         rising-edge clock, synchronous active-high reset
//   rd_addr_i        packed read addresses, port r at [r*RF_SIZE +: RF_SIZE]
//   rd_data_o        packed read data (combinational)
//   busy_o           per read port: addressed register awaits writeback
//   wr_en_i          per write lane enable (higher lane index has priority)
//   wr_addr_i        packed write addresses
//   wr_data_i        packed write data
//   busy_set_en_i    mark busy_set_addr_i as having an in-flight producer
//   busy_set_addr_i  destination register being issued
//   ready_o          clear sweep finished; file accepts traffic
module gpr_multiport #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned RF_SIZE    = 5,
  parameter int unsigned NUM_RD     = 2,
  parameter int unsigned NUM_WR     = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_RD*RF_SIZE-1:0]      rd_addr_i,
  output logic [NUM_RD*DATA_WIDTH-1:0]   rd_data_o,
  output logic [NUM_RD-1:0]              busy_o,
  input  logic [NUM_WR-1:0]              wr_en_i,
  input  logic [NUM_WR*RF_SIZE-1:0]      wr_addr_i,
  input  logic [NUM_WR*DATA_WIDTH-1:0]   wr_data_i,
  input  logic                           busy_set_en_i,
  input  logic [RF_SIZE-1:0]             busy_set_addr_i,
  output logic                           ready_o
);

  localparam int unsigned NREG = 1 << RF_SIZE;

  typedef enum logic {CLEAR, RUN} state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [RF_SIZE-1:0]      r_clr_idx;
  logic [RF_SIZE-1:0]      w_clr_idx_nxt;
  logic                    w_clr_we;
  logic                    r_ready;
  logic [NREG-1:0]         r_busy;
  logic [NREG-1:0]         w_busy_nxt;
  logic                    w_run;
  logic [DATA_WIDTH-1:0]   r_gprs [NREG];

  assign w_run   = (r_state == RUN);
  assign ready_o = r_ready;

  // State, sweep index, ready flag and scoreboard registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= CLEAR;
      r_clr_idx <= '0;
      r_ready   <= 1'b0;
      r_busy    <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_clr_idx <= w_clr_idx_nxt;
      r_ready   <= (w_state_nxt == RUN);
      r_busy    <= w_busy_nxt;
    end
  end

  // Next-state: sweep one register per cycle, leave CLEAR after the last one
  always_comb begin
    w_state_nxt   = r_state;
    w_clr_idx_nxt = r_clr_idx;
    w_clr_we      = 1'b0;
    case (r_state)
      CLEAR: begin
        w_clr_we      = 1'b1;
        w_clr_idx_nxt = r_clr_idx + RF_SIZE'(1);
        if (&r_clr_idx) w_state_nxt = RUN;
      end
      RUN: begin
        w_state_nxt = RUN;
      end
      default: w_state_nxt = CLEAR;
    endcase
  end

  // Scoreboard update: retiring lanes clear, a new issue sets (set wins)
  always_comb begin
    w_busy_nxt = r_busy;
    if (w_run) begin
      for (int unsigned w = 0; w < NUM_WR; w++) begin
        if (wr_en_i[w]) w_busy_nxt[wr_addr_i[w*RF_SIZE +: RF_SIZE]] = 1'b0;
      end
      if (busy_set_en_i && (busy_set_addr_i != '0)) w_busy_nxt[busy_set_addr_i] = 1'b1;
    end
    w_busy_nxt[0] = 1'b0;
  end

  // Register array: sweep writes in CLEAR, lane writes in RUN (later lane overrides)
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (w_clr_we) begin
        r_gprs[r_clr_idx] <= '0;
      end else if (w_run) begin
        for (int unsigned w = 0; w < NUM_WR; w++) begin
          if (wr_en_i[w] && (wr_addr_i[w*RF_SIZE +: RF_SIZE] != '0))
            r_gprs[wr_addr_i[w*RF_SIZE +: RF_SIZE]] <= wr_data_i[w*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

  // Read ports with write-first bypass from the highest matching lane
  for (genvar r = 0; r < NUM_RD; r++) begin : g_rd
    logic [RF_SIZE-1:0]    w_addr;
    logic                  w_hit;
    logic [DATA_WIDTH-1:0] w_byp;

    assign w_addr = rd_addr_i[r*RF_SIZE +: RF_SIZE];

    always_comb begin
      w_hit = 1'b0;
      w_byp = '0;
      for (int unsigned w = 0; w < NUM_WR; w++) begin
        if (wr_en_i[w] && (wr_addr_i[w*RF_SIZE +: RF_SIZE] == w_addr) && (w_addr != '0)) begin
          w_hit = 1'b1;
          w_byp = wr_data_i[w*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end

    assign rd_data_o[r*DATA_WIDTH +: DATA_WIDTH] =
      (!w_run || (w_addr == '0)) ? '0 : (w_hit ? w_byp : r_gprs[w_addr]);

    // A same-cycle writeback already supplies the data, so it is not busy
    assign busy_o[r] = w_run & r_busy[w_addr] & ~w_hit;
  end

endmodule

// File: tb/tb_gpr_multiport.sv
// Self-checking bench for gpr_multiport (default parameters: 64-bit, 32 regs, 2R/2W).
module tb_gpr_multiport;

  logic         clk;
  logic         rst;
  logic [9:0]   rd_addr;
  logic [127:0] rd_data;
  logic [1:0]   busy;
  logic [1:0]   wr_en;
  logic [9:0]   wr_addr;
  logic [127:0] wr_data;
  logic         busy_set_en;
  logic [4:0]   busy_set_addr;
  logic         ready;

  int n_checks = 0;
  int n_errors = 0;

  gpr_multiport dut (
    .clk             (clk),
    .rst             (rst),
    .rd_addr_i       (rd_addr),
    .rd_data_o       (rd_data),
    .busy_o          (busy),
    .wr_en_i         (wr_en),
    .wr_addr_i       (wr_addr),
    .wr_data_i       (wr_data),
    .busy_set_en_i   (busy_set_en),
    .busy_set_addr_i (busy_set_addr),
    .ready_o         (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: architectural state only
  logic [63:0] m_gpr [32];
  bit          m_busy [32];
  int          m_sweep;
  bit          m_ready = 1'b0;
  bit          m_known = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [4:0] rda(input int r);
    logic [9:0] v;
    v = rd_addr;
    return v[r*5 +: 5];
  endfunction

  function automatic bit lane_hit(input int w, input logic [4:0] a);
    return wr_en[w] && (wr_addr[w*5 +: 5] == a) && (a != 5'd0);
  endfunction

  function automatic logic [63:0] exp_rd(input int r);
    logic [4:0] a;
    a = rda(r);
    if (!m_ready || a == 5'd0) return 64'd0;
    for (int w = 1; w >= 0; w--) if (lane_hit(w, a)) return wr_data[w*64 +: 64];
    return m_gpr[a];
  endfunction

  function automatic logic exp_busy(input int r);
    logic [4:0] a;
    a = rda(r);
    if (!m_ready || a == 5'd0) return 1'b0;
    for (int w = 0; w < 2; w++) if (lane_hit(w, a)) return 1'b0;
    return m_busy[a];
  endfunction

  // Model update at every clock edge
  always @(posedge clk) begin
    if (rst) begin
      m_known = 1'b1;
      m_ready = 1'b0;
      m_sweep = 0;
      for (int i = 0; i < 32; i++) begin
        m_gpr[i]  = 64'd0;
        m_busy[i] = 1'b0;
      end
    end else if (m_known && !m_ready) begin
      m_sweep++;
      if (m_sweep == 32) m_ready = 1'b1;
    end else if (m_ready) begin
      for (int w = 0; w < 2; w++) begin
        if (wr_en[w]) begin
          if (wr_addr[w*5 +: 5] != 5'd0) m_gpr[wr_addr[w*5 +: 5]] = wr_data[w*64 +: 64];
          m_busy[wr_addr[w*5 +: 5]] = 1'b0;
        end
      end
      if (busy_set_en && busy_set_addr != 5'd0) m_busy[busy_set_addr] = 1'b1;
    end
  end

  // Continuous comparison against the model on the falling edge
  always @(negedge clk) begin
    if (m_known) begin
      chk("mdl_ready", {63'd0, ready}, {63'd0, m_ready});
      for (int r = 0; r < 2; r++) begin
        chk("mdl_rd_data", rd_data[r*64 +: 64], exp_rd(r));
        chk("mdl_busy", {63'd0, busy[r]}, {63'd0, exp_busy(r)});
      end
    end
  end

  task automatic next_cycle;
    @(posedge clk);
    #1;
    wr_en       = 2'b00;
    busy_set_en = 1'b0;
  endtask

  task automatic wr(input int lane, input logic [4:0] a, input logic [63:0] d);
    wr_en[lane]           = 1'b1;
    wr_addr[lane*5 +: 5]  = a;
    wr_data[lane*64 +: 64] = d;
  endtask

  task automatic set_rd(input int port, input logic [4:0] a);
    rd_addr[port*5 +: 5] = a;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; rd_addr = '0; wr_en = '0; wr_addr = '0; wr_data = '0;
    busy_set_en = 1'b0; busy_set_addr = '0;
    @(posedge clk); #1;
    rst = 1'b0;

    // Sweep: writes and busy-set attempts are ignored, reads give 0
    set_rd(0, 5'd7); set_rd(1, 5'd3);
    wr(0, 5'd7, 64'hDEAD_BEEF);
    busy_set_en = 1'b1; busy_set_addr = 5'd7;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      chk("clr_ready_low", {63'd0, ready}, 64'd0);
      chk("clr_rd0_zero", rd_data[63:0], 64'd0);
      chk("clr_busy0_zero", {63'd0, busy[0]}, 64'd0);
    end
    wr_en = 2'b00; busy_set_en = 1'b0;
    @(negedge clk);
    chk("ready_high", {63'd0, ready}, 64'd1);
    chk("x7_not_kept", rd_data[63:0], 64'd0);
    chk("x7_not_busy", {63'd0, busy[0]}, 64'd0);

    // Same-address writes on both lanes: lane1 wins, bypass then array
    next_cycle;
    wr(0, 5'd5, 64'hAAAA); wr(1, 5'd5, 64'h5555);
    set_rd(0, 5'd5); set_rd(1, 5'd0);
    @(negedge clk);
    chk("x5_bypass", rd_data[63:0], 64'h5555);
    chk("x0_rd1", rd_data[127:64], 64'd0);
    next_cycle;
    @(negedge clk);
    chk("x5_array", rd_data[63:0], 64'h5555);

    // Distinct addresses on the two lanes
    next_cycle;
    wr(0, 5'd12, 64'h1111_0000_0000_1111); wr(1, 5'd13, 64'h2222);
    set_rd(0, 5'd12); set_rd(1, 5'd13);
    @(negedge clk);
    chk("x12_bypass", rd_data[63:0], 64'h1111_0000_0000_1111);
    chk("x13_bypass", rd_data[127:64], 64'h2222);
    next_cycle;
    @(negedge clk);
    chk("x12_array", rd_data[63:0], 64'h1111_0000_0000_1111);
    chk("x13_array", rd_data[127:64], 64'h2222);

    // x0 writes discarded
    next_cycle;
    wr(0, 5'd0, 64'hFFFF); wr(1, 5'd0, 64'hFFFF);
    set_rd(0, 5'd0);
    @(negedge clk);
    chk("x0_same", rd_data[63:0], 64'd0);
    chk("x0_busy", {63'd0, busy[0]}, 64'd0);
    next_cycle;
    @(negedge clk);
    chk("x0_next", rd_data[63:0], 64'd0);

    // Busy set, then writeback clears it with bypassed data
    next_cycle;
    busy_set_en = 1'b1; busy_set_addr = 5'd9;
    set_rd(0, 5'd9);
    @(negedge clk);
    chk("x9_busy_not_yet", {63'd0, busy[0]}, 64'd0);
    next_cycle;
    @(negedge clk);
    chk("x9_busy", {63'd0, busy[0]}, 64'd1);
    wr(0, 5'd9, 64'h42);
    #1;
    chk("x9_wb_busy", {63'd0, busy[0]}, 64'd0);
    chk("x9_wb_data", rd_data[63:0], 64'h42);
    next_cycle;
    @(negedge clk);
    chk("x9_after_busy", {63'd0, busy[0]}, 64'd0);
    chk("x9_after_data", rd_data[63:0], 64'h42);

    // Set and clear of the same register in one cycle: set wins
    next_cycle;
    busy_set_en = 1'b1; busy_set_addr = 5'd3;
    wr(1, 5'd3, 64'h1);
    set_rd(1, 5'd3);
    @(negedge clk);
    chk("x3_same_busy", {63'd0, busy[1]}, 64'd0);
    chk("x3_same_data", rd_data[127:64], 64'h1);
    next_cycle;
    @(negedge clk);
    chk("x3_busy", {63'd0, busy[1]}, 64'd1);
    chk("x3_data", rd_data[127:64], 64'h1);

    // Reset in the middle of a sweep restarts it
    next_cycle;
    rst = 1'b1;
    next_cycle;
    rst = 1'b0;
    repeat (10) next_cycle;
    rst = 1'b1;
    next_cycle;
    rst = 1'b0;
    wr(0, 5'd5, 64'h77);
    set_rd(0, 5'd5); set_rd(1, 5'd3);
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      chk("reclr_ready_low", {63'd0, ready}, 64'd0);
    end
    wr_en = 2'b00;
    @(negedge clk);
    chk("reclr_ready_high", {63'd0, ready}, 64'd1);
    chk("reclr_x5_zero", rd_data[63:0], 64'd0);
    chk("reclr_x3_zero", rd_data[127:64], 64'd0);
    chk("reclr_x3_busy", {63'd0, busy[1]}, 64'd0);

    next_cycle;
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
